// File: rtl/nn_config_pkg.sv
// Shared configuration for the network datapath blocks: serializer FSM
// state encoding and the index-width helper used for word-index ports.
package nn_config_pkg;

  typedef enum logic {SER_IDLE, SER_STREAM} ser_state_t;

  // Width of an index into n words; a single word still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_argmax.sv
// Running signed maximum over a streamed set of words. The tracker restarts
// on index 0; the winning index is latched on the final word and announced
// with a one-cycle pulse the cycle after it. Ties keep the lower index.
module ser_argmax #(
  parameter int data_width = 16,
  parameter int iw         = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld,
  input  logic [iw-1:0]                idx,
  input  logic signed [data_width-1:0] data,
  input  logic                         last,
  output logic [iw-1:0]                max_idx,
  output logic                         max_valid
);

  logic signed [data_width-1:0] best;
  logic [iw-1:0]                best_idx;
  logic signed [data_width-1:0] cand;
  logic [iw-1:0]                cand_idx;

  // Candidate after folding in the current word; strict compare keeps ties low.
  always_comb begin
    cand     = best;
    cand_idx = best_idx;
    if ((idx == '0) || (data > best)) begin
      cand     = data;
      cand_idx = idx;
    end
  end

  // Track the running max and publish the result after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      best      <= '0;
      best_idx  <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= vld && last;
      if (vld) begin
        best     <= cand;
        best_idx <= cand_idx;
        if (last) max_idx <= cand_idx;
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between two fully connected layers. Neuron
// results are gathered into a collect bank (one valid bit per word); a
// complete set is copied into a stream bank and emitted one word per cycle.
// Optional feature macro: LAYER_SER_ARGMAX_EN adds max_idx/max_valid
// (signed argmax of each streamed set) via the ser_argmax sub-module.
module layer_serializer
  import nn_config_pkg::*;
#(
  parameter  int nn         = 10,
  parameter  int data_width = 16,
  localparam int IW         = idx_width(nn)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [nn-1:0]                in_valid,
  input  logic [nn*data_width-1:0]     in_data_flat,
  output logic                         x_valid,
  output logic signed [data_width-1:0] x_out,
  output logic [IW-1:0]                x_idx,
  output logic                         last,
  output logic                         busy,
  output logic                         overflow
`ifdef LAYER_SER_ARGMAX_EN
  ,
  output logic [IW-1:0]                max_idx,
  output logic                         max_valid
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(nn - 1);

  typedef logic signed [data_width-1:0] word_t;

  word_t         coll   [nn];
  word_t         strm   [nn];
  word_t         merged [nn];
  logic [nn-1:0] mask;
  ser_state_t    state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] cnt_nxt;
  logic          at_last;
  logic          complete;
  logic          accept;

  // Collect bank as it would look with this cycle's arrivals folded in.
  always_comb begin
    for (int j = 0; j < nn; j++) begin
      merged[j] = in_valid[j] ? word_t'(in_data_flat[j*data_width +: data_width])
                              : coll[j];
    end
  end

  assign cnt_nxt  = cnt + 1'b1;
  assign at_last  = (state == SER_STREAM) && (cnt == LAST_IDX);
  assign complete = &(mask | in_valid);
  // A new set may only enter the stream bank when it is empty or draining its last word.
  assign accept   = complete && ((state == SER_IDLE) || at_last);

  // Gather words and pending bits; a completed set (kept or dropped) empties the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      for (int j = 0; j < nn; j++) coll[j] <= '0;
    end else begin
      for (int j = 0; j < nn; j++) begin
        if (in_valid[j]) coll[j] <= merged[j];
      end
      mask <= complete ? '0 : (mask | in_valid);
    end
  end

  // Stream FSM: load on accept, emit one word per cycle, flag dropped sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SER_IDLE;
      cnt      <= '0;
      x_out    <= '0;
      last     <= 1'b0;
      overflow <= 1'b0;
      for (int j = 0; j < nn; j++) strm[j] <= '0;
    end else begin
      if (complete && !accept) overflow <= 1'b1;
      if (accept) begin
        for (int j = 0; j < nn; j++) strm[j] <= merged[j];
        state <= SER_STREAM;
        cnt   <= '0;
        x_out <= merged[0];
        last  <= (nn == 1);
      end else if (state == SER_STREAM) begin
        if (at_last) begin
          state <= SER_IDLE;
          cnt   <= '0;
          last  <= 1'b0;
        end else begin
          cnt   <= cnt_nxt;
          x_out <= strm[cnt_nxt];
          last  <= (cnt_nxt == LAST_IDX);
        end
      end
    end
  end

  assign x_valid = (state == SER_STREAM);
  assign busy    = (state == SER_STREAM);
  assign x_idx   = cnt;

`ifdef LAYER_SER_ARGMAX_EN
  ser_argmax #(
    .data_width (data_width),
    .iw         (IW)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .vld       (x_valid),
    .idx       (x_idx),
    .data      (x_out),
    .last      (last),
    .max_idx   (max_idx),
    .max_valid (max_valid)
  );
`endif

endmodule
